// File: rtl/settings_loader_if.sv
// Settings struct definitions shared with the silencer / ECAT-sync consumers,
// plus the BRAM read-port interface between the loader and the controller BRAM.
package settings;

  typedef struct packed {
    logic        update;
    logic        mode;
    logic [15:0] update_rate_intensity;
    logic [15:0] update_rate_phase;
    logic [15:0] completion_steps_intensity;
    logic [15:0] completion_steps_phase;
  } silencer_settings_t;

  typedef struct packed {
    logic        update;
    logic [31:0] ecat_sync_base_cnt;
    logic [63:0] ecat_sync_time;
  } sync_settings_t;

endpackage

interface settings_loader_if;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout;

  modport master (output bram_addr, input bram_dout);
  modport slave  (input bram_addr, output bram_dout);
endinterface

// File: rtl/settings_loader.sv
// Polls the request-flag word in controller BRAM; a toggled bit triggers a burst
// read of that parameter group into shadow registers, then a one-cycle UPDATE.
module settings_loader
  import settings::*;
#(
  parameter logic [7:0]  ADDR_CTL_FLAG      = 8'h00,
  parameter logic [7:0]  ADDR_SILENCER_BASE = 8'h40,
  parameter logic [7:0]  ADDR_SYNC_BASE     = 8'h50,
  parameter int unsigned BRAM_LATENCY       = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  settings_loader_if.master  bram,
  output silencer_settings_t silencer_settings_o,
  output sync_settings_t     sync_settings_o,
  output logic               busy_o
);

  localparam int unsigned SIL_WORDS    = 5;
  localparam int unsigned SYNC_WORDS   = 6;
  localparam int unsigned SHADOW_WORDS = SYNC_WORDS - 1;
  localparam int unsigned CNT_W        = $clog2(SYNC_WORDS + BRAM_LATENCY + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST     = CNT_W'(BRAM_LATENCY - 1);
  localparam logic [CNT_W-1:0] SIL_LAST      = CNT_W'(SIL_WORDS + BRAM_LATENCY - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST     = CNT_W'(SYNC_WORDS + BRAM_LATENCY - 1);
  localparam logic [CNT_W-1:0] SIL_ADDR_END  = CNT_W'(SIL_WORDS - 1);
  localparam logic [CNT_W-1:0] SYNC_ADDR_END = CNT_W'(SYNC_WORDS - 1);

  typedef enum logic [2:0] {
    POLL,
    WAIT_FLAG,
    CHECK,
    LOAD_SIL,
    LOAD_SYNC,
    COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic [1:0]         seen_q, seen_d;
  logic               grp_q, grp_d;
  logic [15:0]        shadow_q [SHADOW_WORDS];
  logic [SHADOW_WORDS-1:0] cap_en;
  silencer_settings_t sil_q, sil_d;
  sync_settings_t     sync_q, sync_d;
  logic               loading;

  assign loading = (state_q == LOAD_SIL) || (state_q == LOAD_SYNC);

  // Word k arrives BRAM_LATENCY cycles after its address, i.e. at load count k+latency.
  for (genvar gi = 0; gi < SHADOW_WORDS; gi++) begin : g_cap
    assign cap_en[gi] = loading && (cnt_q == CNT_W'(gi + BRAM_LATENCY));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SHADOW_WORDS; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < SHADOW_WORDS; i++) begin
        if (cap_en[i]) shadow_q[i] <= bram.bram_dout;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    seen_d         = seen_q;
    grp_d          = grp_q;
    sil_d          = sil_q;
    sil_d.update   = 1'b0;
    sync_d         = sync_q;
    sync_d.update  = 1'b0;

    unique case (state_q)
      POLL: begin
        addr_d  = ADDR_CTL_FLAG;
        cnt_d   = '0;
        state_d = WAIT_FLAG;
      end
      WAIT_FLAG: begin
        if (cnt_q == WAIT_LAST) state_d = CHECK;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      CHECK: begin
        cnt_d = '0;
        if (bram.bram_dout[0] != seen_q[0]) begin
          state_d = LOAD_SIL;
          grp_d   = 1'b0;
          addr_d  = ADDR_SILENCER_BASE;
        end else if (bram.bram_dout[1] != seen_q[1]) begin
          state_d = LOAD_SYNC;
          grp_d   = 1'b1;
          addr_d  = ADDR_SYNC_BASE;
        end else begin
          state_d = POLL;
        end
      end
      LOAD_SIL: begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = (cnt_q < SIL_ADDR_END) ? ADDR_SILENCER_BASE + 8'(cnt_q) + 8'd1 : ADDR_CTL_FLAG;
        // The last word is taken straight from the BRAM so the outputs land in COMMIT.
        if (cnt_q == SIL_LAST) begin
          state_d                          = COMMIT;
          sil_d.update                     = 1'b1;
          sil_d.mode                       = shadow_q[0][0];
          sil_d.update_rate_intensity      = shadow_q[1];
          sil_d.update_rate_phase          = shadow_q[2];
          sil_d.completion_steps_intensity = shadow_q[3];
          sil_d.completion_steps_phase     = bram.bram_dout;
        end
      end
      LOAD_SYNC: begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = (cnt_q < SYNC_ADDR_END) ? ADDR_SYNC_BASE + 8'(cnt_q) + 8'd1 : ADDR_CTL_FLAG;
        if (cnt_q == SYNC_LAST) begin
          state_d                   = COMMIT;
          sync_d.update             = 1'b1;
          sync_d.ecat_sync_base_cnt = {shadow_q[1], shadow_q[0]};
          sync_d.ecat_sync_time     = {bram.bram_dout, shadow_q[4], shadow_q[3], shadow_q[2]};
        end
      end
      COMMIT: begin
        seen_d[grp_q] = ~seen_q[grp_q];
        state_d       = POLL;
      end
      default: state_d = POLL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= POLL;
      cnt_q   <= '0;
      addr_q  <= ADDR_CTL_FLAG;
      seen_q  <= '0;
      grp_q   <= 1'b0;
      sil_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      seen_q  <= seen_d;
      grp_q   <= grp_d;
      sil_q   <= sil_d;
      sync_q  <= sync_d;
    end
  end

  assign bram.bram_addr      = addr_q;
  assign silencer_settings_o = sil_q;
  assign sync_settings_o     = sync_q;
  assign busy_o              = (state_q == LOAD_SIL) || (state_q == LOAD_SYNC) || (state_q == COMMIT);

endmodule
